// File: rtl/epu_pkg.sv
// rtl/epu_pkg.sv - shared EPU bus constants and helpers
package epu_pkg;

    localparam int EPU_DATA_W = 32;

    // W_req is an active-low bit mask: all-ones disables the write, all-zeros writes every bit
    localparam logic [EPU_DATA_W-1:0] WRITE_DIS = '1;
    localparam logic [EPU_DATA_W-1:0] WRITE_ENB = '0;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/sp_ram_intf.sv
// rtl/sp_ram_intf.sv - single-port RAM bus between the EPU switch and a memory responder
interface sp_ram_intf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              cs;
    logic              oe;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] W_req;
    logic [DATA_W-1:0] W_data;
    logic [DATA_W-1:0] R_data;

    modport memory (input cs, oe, addr, W_req, W_data, output R_data);
    modport master (output cs, oe, addr, W_req, W_data, input R_data);
endinterface

// File: rtl/sp_ram_rd_pipe.sv
// rtl/sp_ram_rd_pipe.sv - read-data pipeline behind the RAM read register
module sp_ram_rd_pipe #(
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vld_i,
    input  logic              zero_i,
    input  logic [DATA_W-1:0] raw_i,
    output logic [DATA_W-1:0] data_o
);
    // raw_i only moves on in-range reads, so an out-of-range read is remembered as a zero flag
    logic zero_q;
    logic [DATA_W-1:0] stage0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else if (vld_i) begin
            zero_q <= zero_i;
        end
    end

    assign stage0 = zero_q ? '0 : raw_i;

    generate
        if (READ_LAT >= 2) begin : g_pipe
            logic [READ_LAT-2:0] vld_q;
            logic [DATA_W-1:0]   data_q [READ_LAT-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    vld_q <= '0;
                    for (int s = 0; s < READ_LAT - 1; s++) data_q[s] <= '0;
                end else begin
                    vld_q[0] <= vld_i;
                    if (vld_q[0]) data_q[0] <= stage0;
                    for (int s = 1; s < READ_LAT - 1; s++) begin
                        vld_q[s] <= vld_q[s-1];
                        if (vld_q[s]) data_q[s] <= data_q[s-1];
                    end
                end
            end

            assign data_o = data_q[READ_LAT-2];
        end else begin : g_direct
            assign data_o = stage0;
        end
    endgenerate

endmodule

// File: rtl/sp_ram_responder.sv
// rtl/sp_ram_responder.sv - self-clearing single-port RAM responder for sp_ram_intf
// Optional access counters: SP_RAM_ACCESS_CNT_EN
module sp_ram_responder
    import epu_pkg::*;
#(
    parameter int DATA_W   = EPU_DATA_W,
    parameter int ADDR_W   = 16,
    parameter int DEPTH    = 4096,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    sp_ram_intf.memory  mem,
    output logic        busy_o,
    output logic        oor_err_o,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;
    localparam logic [DATA_W-1:0] WR_DIS = {DATA_W{WRITE_DIS[0]}};

    generate
        if (READ_LAT < 1 || READ_LAT > 2) begin : g_bad_lat
            $error("sp_ram_responder: READ_LAT must be 1 or 2");
        end
    endgenerate

    logic [0:0]        state_q, state_d;
    logic [IDX_W-1:0]  clr_addr_q, clr_addr_d;
    logic              oor_q;
    logic [DATA_W-1:0] ram_q [DEPTH];
    logic [DATA_W-1:0] ram_rd_q;
    logic [DATA_W-1:0] r_data;

    logic              ready, in_range, rd_issue, rd_ok, wr_ok, we;
    logic [IDX_W-1:0]  idx, wr_addr;
    logic [DATA_W-1:0] wr_bits, wr_data;

    assign ready    = (state_q == ST_READY);
    assign in_range = ({1'b0, mem.addr} < (ADDR_W+1)'(DEPTH));
    assign idx      = mem.addr[IDX_W-1:0];
    assign rd_issue = ready && mem.cs && mem.oe;
    assign rd_ok    = rd_issue && in_range;
    assign wr_ok    = ready && mem.cs && in_range && (mem.W_req != WR_DIS);

    // The clear sweep borrows the single write port until READY
    assign we      = rst_n && (wr_ok || !ready);
    assign wr_addr = ready ? idx : clr_addr_q;
    assign wr_bits = ready ? ~mem.W_req : '1;
    assign wr_data = ready ? mem.W_data : '0;

    always_ff @(posedge clk) begin
        if (rd_ok) ram_rd_q <= ram_q[idx];
        for (int b = 0; b < DATA_W; b++) begin
            if (we && wr_bits[b]) ram_q[wr_addr][b] <= wr_data[b];
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        if (state_q == ST_CLEAR) begin
            clr_addr_d = clr_addr_q + IDX_W'(1);
            if (clr_addr_q == IDX_W'(DEPTH - 1)) state_d = ST_READY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            oor_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            if (ready && mem.cs && !in_range) oor_q <= 1'b1;
        end
    end

    sp_ram_rd_pipe #(
        .DATA_W   (DATA_W),
        .READ_LAT (READ_LAT)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (rd_issue),
        .zero_i (!in_range),
        .raw_i  (ram_rd_q),
        .data_o (r_data)
    );

    assign mem.R_data = r_data;
    assign busy_o     = (state_q == ST_CLEAR);
    assign oor_err_o  = oor_q;

`ifdef SP_RAM_ACCESS_CNT_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= sat_inc(rd_cnt_q, rd_ok);
            wr_cnt_q <= sat_inc(wr_cnt_q, wr_ok);
        end
    end

    assign rd_cnt_o = rd_cnt_q;
    assign wr_cnt_o = wr_cnt_q;
`else
    assign rd_cnt_o = '0;
    assign wr_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sp_ram_responder.sv
// tb/tb_sp_ram_responder.sv - randomized model-checked bench for sp_ram_responder (READ_LAT 1 and 2)
module tb_sp_ram_responder;
    import epu_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int DEPTH = 256;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs    = 1'b0;
    logic          oe    = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] w_req = '1;
    logic [DW-1:0] w_data = '0;

    always #5 clk = ~clk;

    sp_ram_intf #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();
    sp_ram_intf #(.DATA_W(DW), .ADDR_W(AW)) bus2 ();

    assign bus1.cs = cs;     assign bus2.cs = cs;
    assign bus1.oe = oe;     assign bus2.oe = oe;
    assign bus1.addr = addr; assign bus2.addr = addr;
    assign bus1.W_req = w_req;   assign bus2.W_req = w_req;
    assign bus1.W_data = w_data; assign bus2.W_data = w_data;

    logic        busy1, oor1, busy2, oor2;
    logic [31:0] rdc1, wrc1, rdc2, wrc2;

    sp_ram_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem(bus1), .busy_o(busy1), .oor_err_o(oor1),
        .rd_cnt_o(rdc1), .wr_cnt_o(wrc1)
    );

    sp_ram_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .mem(bus2), .busy_o(busy2), .oor_err_o(oor2),
        .rd_cnt_o(rdc2), .wr_cnt_o(wrc2)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: word array, cycles of sweep left, last read value per latency
    logic [DW-1:0] mmem [DEPTH];
    int            busy_left = DEPTH;
    bit            moor = 1'b0;
    logic [DW-1:0] last1 = '0;
    logic [DW-1:0] exp2 = '0;
    logic [31:0]   mrd = '0, mwr = '0;
    bit            chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mmem[i] = '0;
            busy_left = DEPTH;
            moor = 1'b0;
            last1 = '0;
            exp2 = '0;
            mrd = '0;
            mwr = '0;
        end else begin
            exp2 = last1;
            if (busy_left > 0) begin
                busy_left--;
            end else if (cs) begin
                if (int'(addr) < DEPTH) begin
                    if (oe) begin
                        last1 = mmem[addr];
                        if (mrd != 32'hFFFF_FFFF) mrd++;
                    end
                    if (w_req != WRITE_DIS) begin
                        mmem[addr] = (mmem[addr] & w_req) | (w_data & ~w_req);
                        if (mwr != 32'hFFFF_FFFF) mwr++;
                    end
                end else begin
                    moor = 1'b1;
                    if (oe) last1 = '0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy1", {31'd0, busy1}, {31'd0, busy_left > 0});
            check("busy2", {31'd0, busy2}, {31'd0, busy_left > 0});
            check("oor1", {31'd0, oor1}, {31'd0, moor});
            check("oor2", {31'd0, oor2}, {31'd0, moor});
            check("rdata_lat1", bus1.R_data, last1);
            check("rdata_lat2", bus2.R_data, exp2);
`ifdef SP_RAM_ACCESS_CNT_EN
            check("rd_cnt", rdc1, mrd);
            check("wr_cnt", wrc2, mwr);
`else
            check("rd_cnt_tied", rdc1 | rdc2, 32'd0);
            check("wr_cnt_tied", wrc1 | wrc2, 32'd0);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] m, input logic [DW-1:0] d);
        cs = 1'b1; oe = 1'b0; addr = a; w_req = m; w_data = d;
        cyc();
        cs = 1'b0;
    endtask

    task automatic rd_lit(input logic [AW-1:0] a, input logic [DW-1:0] expv, input string nm);
        cs = 1'b1; oe = 1'b1; addr = a; w_req = WRITE_DIS;
        cyc();
        cs = 1'b0; oe = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        check({nm, "_lat1"}, bus1.R_data, expv);
        check({nm, "_lat2"}, bus2.R_data, expv);
    endtask

    task automatic rnd_inputs(input int oor_pct);
        cs = ($urandom % 100) < 80;
        oe = $urandom % 2;
        if (($urandom % 100) < oor_pct) addr = AW'(DEPTH + ($urandom % 4));
        else if ($urandom % 2) addr = AW'($urandom % 16);
        else addr = AW'($urandom % DEPTH);
        case ($urandom % 4)
            0: w_req = WRITE_DIS;
            1: w_req = WRITE_ENB;
            2: w_req = $urandom;
            default: w_req = WRITE_DIS;
        endcase
        w_data = $urandom;
    endtask

    task automatic count_busy(input string nm, input bit drive_rnd);
        int n;
        n = 0;
        for (int i = 0; i < DEPTH + 10; i++) begin
            @(negedge clk);
            if (busy1) n++;
            else break;
            if (drive_rnd) rnd_inputs(3);
        end
        check(nm, n, DEPTH);
    endtask

    initial begin
        rst_n = 1'b0;
        cyc();
        chk_en = 1'b1;
        cyc();
        check("busy_at_reset", {31'd0, busy1}, 32'd1);
        check("oor_at_reset", {31'd0, oor1}, 32'd0);
        check("rdata_at_reset", bus2.R_data, 32'd0);
        rst_n = 1'b1;
        count_busy("busy_len", 1'b0);
        cs = 1'b0;
        cyc();

        for (int a = 0; a < DEPTH; a++) begin
            cs = 1'b1; oe = 1'b1; addr = AW'(a); w_req = WRITE_DIS;
            cyc();
        end
        cs = 1'b0;
        cyc();

        wr(16'd5, WRITE_ENB, 32'hDEAD_BEEF);
        rd_lit(16'd5, 32'hDEAD_BEEF, "wr_rd_5");
        wr(16'd5, 32'hFFFF_0000, 32'h0);
        rd_lit(16'd5, 32'hDEAD_0000, "mask_5");

        cs = 1'b1; oe = 1'b1; addr = 16'd7; w_req = WRITE_ENB; w_data = 32'h1234;
        cyc();
        cs = 1'b0; oe = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        check("rd_first_lat1", bus1.R_data, 32'h0);
        check("rd_first_lat2", bus2.R_data, 32'h0);
        rd_lit(16'd7, 32'h1234, "after_wr_7");

        check("oor_before", {31'd0, oor1}, 32'd0);
        rd_lit(AW'(DEPTH), 32'h0, "oor_rd");
        check("oor_set1", {31'd0, oor1}, 32'd1);
        check("oor_set2", {31'd0, oor2}, 32'd1);
        wr(AW'(DEPTH), WRITE_ENB, 32'hFFFF_FFFF);
        cyc();
        check("oor_sticky", {31'd0, oor1}, 32'd1);
        rd_lit(16'd0, 32'h0, "oor_wr_word0");
        rd_lit(16'd5, 32'hDEAD_0000, "oor_wr_word5");

        for (int i = 0; i < 1500; i++) begin
            rnd_inputs(0);
            cyc();
        end
        for (int i = 0; i < 800; i++) begin
            rnd_inputs(3);
            cyc();
        end

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rnd_inputs(3);
            cyc();
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        count_busy("busy_len_restart", 1'b1);
        cs = 1'b0;
        cyc();
        rd_lit(16'd5, 32'h0, "cleared_5");
        check("oor_cleared", {31'd0, oor1}, 32'd0);

        for (int i = 0; i < 1500; i++) begin
            rnd_inputs(2);
            cyc();
        end
        cs = 1'b0;
        cyc();
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
